// File: rtl/iq_pkg.sv
// ----------------------------------------------------------------------------
// iq_pkg
// Shared sizing constants and index/count/register typedefs for the
// instruction-queue dispatch controller and its readiness scoreboard.
// The localparams are the default geometry: 64 queue entries and
// 128 physical registers. The typedefs match that default geometry.
// ----------------------------------------------------------------------------
package iq_pkg;

    localparam int IQ_ENTRIES         = 64;
    localparam int IQ_ADDR_WIDTH      = $clog2(IQ_ENTRIES);
    localparam int IQ_PHYS_COUNT      = 128;
    localparam int IQ_PHYS_ADDR_WIDTH = $clog2(IQ_PHYS_COUNT);

    // Queue slot index (head/tail pointer).
    typedef logic [IQ_ADDR_WIDTH-1:0]      q_idx_t;
    // Queue occupancy. It has one extra bit so that a full queue is representable.
    typedef logic [IQ_ADDR_WIDTH:0]        q_cnt_t;
    // Physical register number.
    typedef logic [IQ_PHYS_ADDR_WIDTH-1:0] preg_t;

endpackage : iq_pkg

// File: rtl/phys_ready_scoreboard.sv
// ----------------------------------------------------------------------------
// phys_ready_scoreboard
// Holds one ready bit per physical register. A set bit means the value is
// available. All updates are registered, so a writeback is visible on the
// read ports one cycle later.
//
// Ports
//   clk          in   clock
//   sync_rst_n   in   synchronous active-low reset (all bits -> ready)
//   en_i         in   update enable; when low, all bits hold
//   flush_i      in   mark every register ready (with en_i)
//   set_valid_i  in   writeback: mark set_addr_i ready
//   set_addr_i   in   register that was written back
//   clr_valid_i  in   allocation: mark clr_addr_i not ready
//   clr_addr_i   in   newly allocated destination register
//   rd_addr_i    in   two combinational lookup addresses
//   rd_ready_o   out  ready bit for each lookup address
// ----------------------------------------------------------------------------
module phys_ready_scoreboard
    import iq_pkg::*;
#(
    parameter int PHYS_COUNT      = IQ_PHYS_COUNT,
    parameter int PHYS_ADDR_WIDTH = $clog2(PHYS_COUNT)
) (
    input  logic                            clk,
    input  logic                            sync_rst_n,
    input  logic                            en_i,
    input  logic                            flush_i,
    input  logic                            set_valid_i,
    input  logic [PHYS_ADDR_WIDTH-1:0]      set_addr_i,
    input  logic                            clr_valid_i,
    input  logic [PHYS_ADDR_WIDTH-1:0]      clr_addr_i,
    input  logic [1:0][PHYS_ADDR_WIDTH-1:0] rd_addr_i,
    output logic [1:0]                      rd_ready_o
);

    logic [PHYS_COUNT-1:0] sb_q;
    logic [PHYS_COUNT-1:0] sb_d;

    // The clear is applied after the set. When a register is written back and
    // re-allocated in the same cycle, the new producer therefore owns it
    // (clear wins). A flush overrides both.
    always_comb begin
        sb_d = sb_q;
        if (set_valid_i) begin
            sb_d[set_addr_i] = 1'b1;
        end
        if (clr_valid_i) begin
            sb_d[clr_addr_i] = 1'b0;
        end
        if (flush_i) begin
            sb_d = '1;
        end
    end

    always_ff @(posedge clk) begin
        if (!sync_rst_n) begin
            sb_q <= '1;
        end else if (en_i) begin
            sb_q <= sb_d;
        end
    end

    always_comb begin
        rd_ready_o = '0;
        for (int i = 0; i < 2; i++) begin
            rd_ready_o[i] = sb_q[rd_addr_i[i]];
        end
    end

endmodule : phys_ready_scoreboard

// File: rtl/iq_dispatch_ctrl.sv
// ----------------------------------------------------------------------------
// iq_dispatch_ctrl
// Allocation and issue controller for the instruction-queue storage array.
// Renamed ops are written at the tail. Ops leave in order from the head once
// both of the head op's sources are ready in the physical-register scoreboard.
// ENTRIES must be a power of two and at least 2. The pointers wrap naturally
// at ADDR_WIDTH bits.
//
// Ports
//   clk, sync_rst_n   clock and synchronous active-low reset
//   clk_en            global enable; when low, all state holds and no strobes
//   flush             squash every queued op and mark all registers ready
//   disp_valid/ready  dispatch handshake (ready = !full && !flush)
//   disp_dest_valid   the dispatched op allocates disp_dest_addr
//   disp_dest_addr    destination physical register
//   wr_en             queue write strobe (dispatch fire)
//   queue_wr_addr     tail pointer
//   head_src_addr     two source registers of the head entry (queue read data)
//   head_src_valid    per-source "used" flags of the head entry
//   rd_en             queue read strobe (issue fire)
//   queue_rd_addr     head pointer
//   issue_valid       head op can issue
//   issue_ready       execute port accepts the op
//   wb_valid/wb_addr  writeback broadcast
//   count             occupancy; full and empty are derived from count only
// ----------------------------------------------------------------------------
module iq_dispatch_ctrl
    import iq_pkg::*;
#(
    parameter int ENTRIES         = IQ_ENTRIES,
    parameter int ADDR_WIDTH      = $clog2(ENTRIES),
    parameter int PHYS_COUNT      = IQ_PHYS_COUNT,
    parameter int PHYS_ADDR_WIDTH = $clog2(PHYS_COUNT)
) (
    input  logic                            clk,
    input  logic                            sync_rst_n,
    input  logic                            clk_en,
    input  logic                            flush,
    input  logic                            disp_valid,
    output logic                            disp_ready,
    input  logic                            disp_dest_valid,
    input  logic [PHYS_ADDR_WIDTH-1:0]      disp_dest_addr,
    output logic                            wr_en,
    output logic [ADDR_WIDTH-1:0]           queue_wr_addr,
    input  logic [1:0][PHYS_ADDR_WIDTH-1:0] head_src_addr,
    input  logic [1:0]                      head_src_valid,
    output logic                            rd_en,
    output logic [ADDR_WIDTH-1:0]           queue_rd_addr,
    output logic                            issue_valid,
    input  logic                            issue_ready,
    input  logic                            wb_valid,
    input  logic [PHYS_ADDR_WIDTH-1:0]      wb_addr,
    output logic [ADDR_WIDTH:0]             count,
    output logic                            full,
    output logic                            empty
);

    localparam logic [ADDR_WIDTH:0]   FULL_CNT = (ADDR_WIDTH+1)'(ENTRIES);
    localparam logic [ADDR_WIDTH:0]   CNT_ONE  = (ADDR_WIDTH+1)'(1);
    localparam logic [ADDR_WIDTH-1:0] IDX_ONE  = ADDR_WIDTH'(1);

    logic [ADDR_WIDTH-1:0] head_q, head_d;
    logic [ADDR_WIDTH-1:0] tail_q, tail_d;
    logic [ADDR_WIDTH:0]   count_q, count_d;

    logic       disp_fire;
    logic       issue_fire;
    logic [1:0] src_rdy;
    logic [1:0] src_ok;

    // ------------------------------------------------------------------
    // Handshakes
    // ------------------------------------------------------------------
    assign full  = (count_q == FULL_CNT);
    assign empty = (count_q == '0);

    // Dispatch ready looks only at the registered occupancy. An issue in the
    // same cycle does not free a slot for a dispatch until the next cycle.
    assign disp_ready = !full && !flush;

    // A source is satisfied when it is unused or its producer has written back.
    always_comb begin
        src_ok = '0;
        for (int i = 0; i < 2; i++) begin
            src_ok[i] = !head_src_valid[i] || src_rdy[i];
        end
    end

    // empty comes from the registered count. An op written this cycle
    // therefore cannot issue before the next cycle.
    assign issue_valid = !empty && !flush && (&src_ok);

    // Both fires are also gated by reset, so that no strobe leaves the block
    // while it is being reset.
    assign disp_fire  = sync_rst_n && clk_en && disp_valid && disp_ready;
    assign issue_fire = sync_rst_n && clk_en && issue_valid && issue_ready;

    assign wr_en         = disp_fire;
    assign rd_en         = issue_fire;
    assign queue_wr_addr = tail_q;
    assign queue_rd_addr = head_q;
    assign count         = count_q;

    // ------------------------------------------------------------------
    // Pointer and occupancy next state
    // ------------------------------------------------------------------
    always_comb begin
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        if (flush) begin
            head_d  = '0;
            tail_d  = '0;
            count_d = '0;
        end else begin
            if (disp_fire) begin
                tail_d = tail_q + IDX_ONE;
            end
            if (issue_fire) begin
                head_d = head_q + IDX_ONE;
            end
            unique case ({disp_fire, issue_fire})
                2'b10:   count_d = count_q + CNT_ONE;
                2'b01:   count_d = count_q - CNT_ONE;
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!sync_rst_n) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else if (clk_en) begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

    // ------------------------------------------------------------------
    // Physical register readiness
    // ------------------------------------------------------------------
    phys_ready_scoreboard #(
        .PHYS_COUNT      (PHYS_COUNT),
        .PHYS_ADDR_WIDTH (PHYS_ADDR_WIDTH)
    ) u_sb (
        .clk         (clk),
        .sync_rst_n  (sync_rst_n),
        .en_i        (clk_en),
        .flush_i     (flush),
        .set_valid_i (wb_valid),
        .set_addr_i  (wb_addr),
        .clr_valid_i (disp_fire && disp_dest_valid),
        .clr_addr_i  (disp_dest_addr),
        .rd_addr_i   (head_src_addr),
        .rd_ready_o  (src_rdy)
    );

endmodule : iq_dispatch_ctrl

// File: tb/tb_iq_dispatch_ctrl.sv
// ----------------------------------------------------------------------------
// tb_iq_dispatch_ctrl
// Scenario tasks drive the dispatch controller. Expected queue slots are
// queued when an op is written and popped when the DUT strobes rd_en.
// ----------------------------------------------------------------------------
module tb_iq_dispatch_ctrl;

    localparam int AW = 6;
    localparam int PW = 7;

    logic                 clk;
    logic                 sync_rst_n;
    logic                 clk_en;
    logic                 flush;
    logic                 disp_valid;
    logic                 disp_ready;
    logic                 disp_dest_valid;
    logic [PW-1:0]        disp_dest_addr;
    logic                 wr_en;
    logic [AW-1:0]        queue_wr_addr;
    logic [1:0][PW-1:0]   head_src_addr;
    logic [1:0]           head_src_valid;
    logic                 rd_en;
    logic [AW-1:0]        queue_rd_addr;
    logic                 issue_valid;
    logic                 issue_ready;
    logic                 wb_valid;
    logic [PW-1:0]        wb_addr;
    logic [AW:0]          count;
    logic                 full;
    logic                 empty;

    int errors = 0;
    int checks = 0;
    logic [AW-1:0] exp_q[$];
    logic [AW-1:0] exp_tail;
    logic [AW-1:0] e;

    iq_dispatch_ctrl dut (
        .clk             (clk),
        .sync_rst_n      (sync_rst_n),
        .clk_en          (clk_en),
        .flush           (flush),
        .disp_valid      (disp_valid),
        .disp_ready      (disp_ready),
        .disp_dest_valid (disp_dest_valid),
        .disp_dest_addr  (disp_dest_addr),
        .wr_en           (wr_en),
        .queue_wr_addr   (queue_wr_addr),
        .head_src_addr   (head_src_addr),
        .head_src_valid  (head_src_valid),
        .rd_en           (rd_en),
        .queue_rd_addr   (queue_rd_addr),
        .issue_valid     (issue_valid),
        .issue_ready     (issue_ready),
        .wb_valid        (wb_valid),
        .wb_addr         (wb_addr),
        .count           (count),
        .full            (full),
        .empty           (empty)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    // Advance to 1 time unit after the next rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Let the combinational outputs settle after an input change.
    task automatic settle();
        #1;
    endtask

    // Drive one dispatch cycle: check the write strobe and slot, then record the slot.
    task automatic disp_one(input logic dv, input logic [PW-1:0] da);
        disp_valid = 1'b1; disp_dest_valid = dv; disp_dest_addr = da;
        settle();
        checks++;
        if (wr_en !== 1'b1 || queue_wr_addr !== exp_tail) begin
            errors++;
            $display("FAIL disp_write: wr_en=%0b addr=%0d, want 1/%0d", wr_en, queue_wr_addr, exp_tail);
        end
        exp_q.push_back(exp_tail);
        exp_tail = exp_tail + 1'b1;
        tick();
        disp_valid = 1'b0; disp_dest_valid = 1'b0;
    endtask

    task automatic test_reset();
        sync_rst_n = 1'b0; clk_en = 1'b1; flush = 1'b0;
        disp_valid = 1'b1; disp_dest_valid = 1'b0; disp_dest_addr = '0;
        head_src_addr = '0; head_src_valid = '0; issue_ready = 1'b1;
        wb_valid = 1'b0; wb_addr = '0;
        repeat (3) tick();
        settle();
        checks++;
        if (wr_en !== 1'b0 || rd_en !== 1'b0) begin
            errors++;
            $display("FAIL reset_strobes: wr_en=%0b rd_en=%0b, want 0/0", wr_en, rd_en);
        end
        sync_rst_n = 1'b1; disp_valid = 1'b0; issue_ready = 1'b0;
        settle();
        checks++;
        if (count !== 7'd0 || empty !== 1'b1 || full !== 1'b0) begin
            errors++;
            $display("FAIL reset_count: count=%0d empty=%0b full=%0b, want 0/1/0", count, empty, full);
        end
        checks++;
        if (disp_ready !== 1'b1 || issue_valid !== 1'b0) begin
            errors++;
            $display("FAIL reset_hs: disp_ready=%0b issue_valid=%0b, want 1/0", disp_ready, issue_valid);
        end
        checks++;
        if (queue_wr_addr !== 6'd0 || queue_rd_addr !== 6'd0) begin
            errors++;
            $display("FAIL reset_ptrs: wr=%0d rd=%0d, want 0/0", queue_wr_addr, queue_rd_addr);
        end
        exp_tail = '0;
        tick();
    endtask

    task automatic test_fill();
        issue_ready = 1'b0;
        for (int i = 0; i < 64; i++) begin
            disp_valid = 1'b1;
            settle();
            if (i == 0) begin
                checks++;
                if (issue_valid !== 1'b0) begin
                    errors++;
                    $display("FAIL fill_write_then_read: issue_valid=%0b, want 0", issue_valid);
                end
            end
            disp_one(1'b0, '0);
        end
        disp_valid = 1'b1;
        settle();
        checks++;
        if (full !== 1'b1 || disp_ready !== 1'b0 || count !== 7'd64) begin
            errors++;
            $display("FAIL fill_full: full=%0b disp_ready=%0b count=%0d, want 1/0/64", full, disp_ready, count);
        end
        checks++;
        if (wr_en !== 1'b0) begin
            errors++;
            $display("FAIL fill_65th: wr_en=%0b, want 0", wr_en);
        end
        tick();
        checks++;
        if (count !== 7'd64 || queue_wr_addr !== 6'd0) begin
            errors++;
            $display("FAIL fill_hold: count=%0d tail=%0d, want 64/0", count, queue_wr_addr);
        end
    endtask

    task automatic test_drain();
        int pulses;
        pulses = 0;
        issue_ready = 1'b1;
        disp_valid = 1'b1;
        settle();
        checks++;
        if (disp_ready !== 1'b0 || wr_en !== 1'b0 || rd_en !== 1'b1) begin
            errors++;
            $display("FAIL drain_full_issue: disp_ready=%0b wr_en=%0b rd_en=%0b, want 0/0/1", disp_ready, wr_en, rd_en);
        end
        disp_valid = 1'b0;
        settle();
        for (int c = 0; c < 200 && exp_q.size() > 0; c++) begin
            if (rd_en === 1'b1) begin
                e = exp_q.pop_front();
                pulses++;
                checks++;
                if (queue_rd_addr !== e) begin
                    errors++;
                    $display("FAIL drain_rd_addr: got %0d, want %0d", queue_rd_addr, e);
                end
            end
            tick();
        end
        checks++;
        if (pulses != 64 || exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain_pulses: got %0d rd_en pulses, want 64", pulses);
        end
        checks++;
        if (empty !== 1'b1 || count !== 7'd0 || queue_rd_addr !== 6'd0 || queue_wr_addr !== 6'd0) begin
            errors++;
            $display("FAIL drain_end: empty=%0b count=%0d rd=%0d wr=%0d, want 1/0/0/0", empty, count, queue_rd_addr, queue_wr_addr);
        end
        issue_ready = 1'b0;
    endtask

    task automatic test_dependency();
        issue_ready = 1'b0;
        disp_one(1'b1, 7'd5);
        disp_one(1'b0, '0);
        head_src_valid = 2'b00; issue_ready = 1'b1;
        settle();
        e = exp_q.pop_front();
        checks++;
        if (issue_valid !== 1'b1 || rd_en !== 1'b1 || queue_rd_addr !== e) begin
            errors++;
            $display("FAIL dep_issue_a: iv=%0b rd_en=%0b addr=%0d, want 1/1/%0d", issue_valid, rd_en, queue_rd_addr, e);
        end
        tick();
        head_src_valid = 2'b01; head_src_addr[0] = 7'd5; head_src_addr[1] = 7'd0;
        settle();
        for (int c = 0; c < 3; c++) begin
            checks++;
            if (issue_valid !== 1'b0 || rd_en !== 1'b0) begin
                errors++;
                $display("FAIL dep_stall: iv=%0b rd_en=%0b, want 0/0", issue_valid, rd_en);
            end
            tick();
        end
        wb_valid = 1'b1; wb_addr = 7'd5;
        settle();
        checks++;
        if (issue_valid !== 1'b0) begin
            errors++;
            $display("FAIL dep_no_bypass: iv=%0b, want 0", issue_valid);
        end
        tick();
        wb_valid = 1'b0;
        settle();
        e = exp_q.pop_front();
        checks++;
        if (issue_valid !== 1'b1 || rd_en !== 1'b1 || queue_rd_addr !== e) begin
            errors++;
            $display("FAIL dep_wake: iv=%0b rd_en=%0b addr=%0d, want 1/1/%0d", issue_valid, rd_en, queue_rd_addr, e);
        end
        tick();
        head_src_valid = 2'b00; issue_ready = 1'b0;
        checks++;
        if (empty !== 1'b1) begin
            errors++;
            $display("FAIL dep_empty: empty=%0b, want 1", empty);
        end
    endtask

    task automatic test_clear_wins();
        issue_ready = 1'b0;
        wb_valid = 1'b1; wb_addr = 7'd7;
        disp_one(1'b1, 7'd7);
        wb_valid = 1'b0;
        head_src_valid = 2'b10; head_src_addr[1] = 7'd7; head_src_addr[0] = 7'd0;
        issue_ready = 1'b1;
        settle();
        checks++;
        if (issue_valid !== 1'b0) begin
            errors++;
            $display("FAIL clear_wins: iv=%0b, want 0 (p7 not ready)", issue_valid);
        end
        wb_valid = 1'b1; wb_addr = 7'd7;
        tick();
        wb_valid = 1'b0;
        settle();
        e = exp_q.pop_front();
        checks++;
        if (issue_valid !== 1'b1 || rd_en !== 1'b1 || queue_rd_addr !== e) begin
            errors++;
            $display("FAIL clear_wins_wake: iv=%0b rd_en=%0b addr=%0d, want 1/1/%0d", issue_valid, rd_en, queue_rd_addr, e);
        end
        tick();
        head_src_valid = 2'b00; issue_ready = 1'b0;
    endtask

    task automatic test_flush();
        issue_ready = 1'b0;
        for (int i = 0; i < 10; i++) begin
            disp_one(i == 0, 7'd20);
        end
        disp_valid = 1'b1; flush = 1'b1; issue_ready = 1'b1;
        settle();
        checks++;
        if (count !== 7'd10 || wr_en !== 1'b0 || disp_ready !== 1'b0) begin
            errors++;
            $display("FAIL flush_block_disp: count=%0d wr_en=%0b dr=%0b, want 10/0/0", count, wr_en, disp_ready);
        end
        checks++;
        if (issue_valid !== 1'b0 || rd_en !== 1'b0) begin
            errors++;
            $display("FAIL flush_block_issue: iv=%0b rd_en=%0b, want 0/0", issue_valid, rd_en);
        end
        tick();
        flush = 1'b0; disp_valid = 1'b0; issue_ready = 1'b0;
        exp_q.delete();
        exp_tail = '0;
        settle();
        checks++;
        if (count !== 7'd0 || empty !== 1'b1 || queue_wr_addr !== 6'd0 || queue_rd_addr !== 6'd0) begin
            errors++;
            $display("FAIL flush_state: count=%0d empty=%0b wr=%0d rd=%0d, want 0/1/0/0", count, empty, queue_wr_addr, queue_rd_addr);
        end
        disp_one(1'b0, '0);
        head_src_valid = 2'b01; head_src_addr[0] = 7'd20; issue_ready = 1'b1;
        settle();
        e = exp_q.pop_front();
        checks++;
        if (issue_valid !== 1'b1 || rd_en !== 1'b1 || queue_rd_addr !== e) begin
            errors++;
            $display("FAIL flush_sb_ready: iv=%0b rd_en=%0b addr=%0d, want 1/1/%0d", issue_valid, rd_en, queue_rd_addr, e);
        end
        tick();
        head_src_valid = 2'b00; issue_ready = 1'b0;
    endtask

    task automatic test_clk_en();
        issue_ready = 1'b0;
        for (int i = 0; i < 3; i++) disp_one(1'b0, '0);
        clk_en = 1'b0; disp_valid = 1'b1; issue_ready = 1'b1;
        settle();
        checks++;
        if (wr_en !== 1'b0 || rd_en !== 1'b0) begin
            errors++;
            $display("FAIL clken_strobes: wr_en=%0b rd_en=%0b, want 0/0", wr_en, rd_en);
        end
        checks++;
        if (issue_valid !== 1'b1 || disp_ready !== 1'b1) begin
            errors++;
            $display("FAIL clken_comb: iv=%0b dr=%0b, want 1/1", issue_valid, disp_ready);
        end
        tick();
        tick();
        checks++;
        if (count !== 7'd3 || queue_wr_addr !== exp_tail || queue_rd_addr !== exp_q[0]) begin
            errors++;
            $display("FAIL clken_hold: count=%0d wr=%0d rd=%0d, want 3/%0d/%0d", count, queue_wr_addr, queue_rd_addr, exp_tail, exp_q[0]);
        end
        clk_en = 1'b1; disp_valid = 1'b0;
        settle();
        for (int c = 0; c < 20 && exp_q.size() > 0; c++) begin
            if (rd_en === 1'b1) begin
                e = exp_q.pop_front();
                checks++;
                if (queue_rd_addr !== e) begin
                    errors++;
                    $display("FAIL clken_drain: got %0d, want %0d", queue_rd_addr, e);
                end
            end
            tick();
        end
        checks++;
        if (exp_q.size() != 0 || empty !== 1'b1) begin
            errors++;
            $display("FAIL clken_drain_end: left=%0d empty=%0b, want 0/1", exp_q.size(), empty);
        end
        issue_ready = 1'b0;
    endtask

    task automatic test_back_to_back();
        issue_ready = 1'b1;
        disp_valid = 1'b1;
        settle();
        checks++;
        if (issue_valid !== 1'b0 || rd_en !== 1'b0) begin
            errors++;
            $display("FAIL b2b_empty_write: iv=%0b rd_en=%0b, want 0/0", issue_valid, rd_en);
        end
        disp_one(1'b0, '0);
        for (int c = 0; c < 5; c++) begin
            disp_valid = 1'b1;
            settle();
            e = exp_q.pop_front();
            checks++;
            if (rd_en !== 1'b1 || wr_en !== 1'b1 || queue_rd_addr !== e || queue_wr_addr !== exp_tail) begin
                errors++;
                $display("FAIL b2b_both: rd_en=%0b wr_en=%0b rd=%0d wr=%0d, want 1/1/%0d/%0d", rd_en, wr_en, queue_rd_addr, queue_wr_addr, e, exp_tail);
            end
            exp_q.push_back(exp_tail);
            exp_tail = exp_tail + 1'b1;
            tick();
            checks++;
            if (count !== 7'd1) begin
                errors++;
                $display("FAIL b2b_count: count=%0d, want 1", count);
            end
        end
        disp_valid = 1'b0;
        settle();
        e = exp_q.pop_front();
        checks++;
        if (rd_en !== 1'b1 || queue_rd_addr !== e) begin
            errors++;
            $display("FAIL b2b_last: rd_en=%0b rd=%0d, want 1/%0d", rd_en, queue_rd_addr, e);
        end
        tick();
        issue_ready = 1'b0;
        checks++;
        if (empty !== 1'b1 || count !== 7'd0) begin
            errors++;
            $display("FAIL b2b_end: empty=%0b count=%0d, want 1/0", empty, count);
        end
    endtask

    initial begin
        test_reset();
        test_fill();
        test_drain();
        test_dependency();
        test_clear_wins();
        test_flush();
        test_clk_en();
        test_back_to_back();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule : tb_iq_dispatch_ctrl
